// File: rtl/button_debounce_pulse.sv
// Push-button conditioner: two-FF synchroniser, debounce, and a one-clock step pulse per press,
// with optional auto-repeat while the button stays held.
`timescale 1ns/1ps
module button_debounce_pulse #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 1000,
    parameter int REPEAT_PERIOD   = 250
) (
    input  logic clk,
    input  logic reset,
    input  logic button_in,
    input  logic repeat_en,
    output logic btn_level,
    output logic btn_pulse
);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX);

    localparam logic [DW-1:0] DC_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);
    localparam logic [RW-1:0] RC_SAT  = '1;

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT, S_HELD} state_t;

    logic          r_s1;
    logic          r_s2;
    logic [DW-1:0] r_dcnt;
    logic          r_level;
    logic          r_pulse;
    logic [RW-1:0] r_rcnt;
    state_t        r_state;

    logic          w_differ;
    logic          w_accept;
    logic          w_press;
    logic          w_release;
    logic [RW-1:0] w_rcnt_inc;
    state_t        w_state_nxt;
    logic          w_pulse_nxt;
    logic [RW-1:0] w_rcnt_nxt;

    assign w_differ   = (r_s2 != r_level);
    assign w_accept   = w_differ && (r_dcnt == DC_LAST);
    assign w_press    = w_accept && !r_level;
    assign w_release  = w_accept && r_level;
    assign w_rcnt_inc = (r_rcnt == RC_SAT) ? r_rcnt : r_rcnt + RW'(1);

    // Any sample equal to the current level breaks the run and restarts the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_dcnt  <= '0;
            r_level <= 1'b0;
        end else begin
            r_s1 <= button_in;
            r_s2 <= r_s1;
            if (w_accept) begin
                r_level <= r_s2;
                r_dcnt  <= '0;
            end else if (w_differ) begin
                r_dcnt <= r_dcnt + DW'(1);
            end else begin
                r_dcnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_pulse <= 1'b0;
            r_rcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pulse <= w_pulse_nxt;
            r_rcnt  <= w_rcnt_nxt;
        end
    end

    // An accepted release always takes priority over a repeat expiry in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_press) w_state_nxt = S_DELAY;
            S_DELAY: begin
                if (w_release)               w_state_nxt = S_IDLE;
                else if (r_rcnt == RD_LAST)  w_state_nxt = repeat_en ? S_REPEAT : S_HELD;
            end
            S_REPEAT: begin
                if (w_release)       w_state_nxt = S_IDLE;
                else if (!repeat_en) w_state_nxt = S_HELD;
            end
            S_HELD:   if (w_release) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_pulse_nxt = 1'b0;
        w_rcnt_nxt  = w_rcnt_inc;
        case (r_state)
            S_IDLE: begin
                if (w_press) begin
                    w_pulse_nxt = 1'b1;
                    w_rcnt_nxt  = '0;
                end
            end
            S_DELAY: begin
                if (!w_release && (r_rcnt == RD_LAST) && repeat_en) begin
                    w_pulse_nxt = 1'b1;
                    w_rcnt_nxt  = '0;
                end
            end
            S_REPEAT: begin
                if (!w_release && repeat_en && (r_rcnt == RP_LAST)) begin
                    w_pulse_nxt = 1'b1;
                    w_rcnt_nxt  = '0;
                end
            end
            default: ;
        endcase
    end

    assign btn_level = r_level;
    assign btn_pulse = r_pulse;

endmodule

// File: tb/tb_button_debounce_pulse.sv
// Bench for button_debounce_pulse: spec-derived vector table, hand-written corner sequences,
// and randomized stimulus against a timestamp-based reference model.
`timescale 1ns/1ps
module tb_button_debounce_pulse;
    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;
    localparam int HN = D + 4;

    logic clk = 1'b0;
    logic reset;
    logic button_in, repeat_en;
    logic btn_level, btn_pulse;
    logic btn2, btn2_level, btn2_pulse;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int base  = 0;
    int pulses[$];
    int lvl_hi_cnt = 0;
    int p2cnt = 0;
    int consec2 = 0;
    logic prev2 = 1'b0;

    // Reference model state: history of raw samples and absolute due times.
    bit  hist[$];
    bit  m_level, m_pulse, m_armed, m_inrep;
    int  m_k, m_due;

    typedef struct {
        logic btn;
        logic ren;
        logic exp_level;
        logic exp_pulse;
    } vec_t;
    vec_t tbl[48];

    button_debounce_pulse #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
        .clk(clk), .reset(reset), .button_in(button_in), .repeat_en(repeat_en),
        .btn_level(btn_level), .btn_pulse(btn_pulse));

    button_debounce_pulse #(.DEBOUNCE_CYCLES(16), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut16 (
        .clk(clk), .reset(reset), .button_in(btn2), .repeat_en(1'b0),
        .btn_level(btn2_level), .btn_pulse(btn2_pulse));

    always #10 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0b expected %0b", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < HN; i++) hist.push_front(1'b0);
        m_level = 0; m_pulse = 0; m_armed = 0; m_inrep = 0;
    endtask

    // A change is accepted once the last D synchronised samples all differ from the level.
    task automatic model_update();
        bit acc;
        m_k++;
        hist.push_front(button_in);
        void'(hist.pop_back());
        acc = 1;
        for (int j = 2; j < D + 2; j++) if (hist[j] == m_level) acc = 0;
        m_pulse = 0;
        if (acc && m_level) begin
            m_level = 0; m_armed = 0;
        end else if (acc) begin
            m_level = 1; m_pulse = 1; m_armed = 1; m_inrep = 0; m_due = m_k + RD;
        end else if (m_armed) begin
            if (m_inrep && !repeat_en) m_armed = 0;
            else if (m_k == m_due) begin
                if (repeat_en) begin
                    m_pulse = 1; m_due = m_k + RP; m_inrep = 1;
                end else m_armed = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset) model_reset(); else model_update();
        #1;
        cyc++;
        check("model_level", btn_level, m_level);
        check("model_pulse", btn_pulse, m_pulse);
        if (btn_pulse) pulses.push_back(cyc - base);
        if (btn_level) lvl_hi_cnt++;
        if (btn2_pulse) p2cnt++;
        if (btn2_pulse && prev2) consec2++;
        prev2 = btn2_pulse;
    endtask

    task automatic run(input logic b, input logic r, input int n);
        button_in = b;
        repeat_en = r;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic start_seq();
        base = cyc;
        pulses.delete();
        lvl_hi_cnt = 0;
    endtask

    task automatic check_pulses(input string name, input int exp[$]);
        check_int({name, "_count"}, pulses.size(), exp.size());
        for (int i = 0; i < exp.size() && i < pulses.size(); i++)
            check_int({name, "_time"}, pulses[i], exp[i]);
    endtask

    initial begin
        int exp4[$];
        int exp5[$];
        int exp1[$];
        int none[$];
        m_k = 0; m_due = 0;
        reset = 1'b0; button_in = 1'b0; repeat_en = 1'b0; btn2 = 1'b0;
        model_reset();
        #1;
        check("rst_level", btn_level, 1'b0);
        check("rst_pulse", btn_pulse, 1'b0);
        for (int i = 0; i < 3; i++) step();
        reset = 1'b1;
        run(0, 0, 10);

        // Clean press: expectations written straight from the stated latencies.
        for (int i = 0; i < 48; i++) begin
            tbl[i].btn       = (i < 32);
            tbl[i].ren       = 1'b0;
            tbl[i].exp_level = ((i + 1) >= 6) && ((i + 1) < 38);
            tbl[i].exp_pulse = ((i + 1) == 6);
        end
        for (int i = 0; i < 48; i++) begin
            button_in = tbl[i].btn;
            repeat_en = tbl[i].ren;
            step();
            check("tbl_level", btn_level, tbl[i].exp_level);
            check("tbl_pulse", btn_pulse, tbl[i].exp_pulse);
        end

        // Bounce every 2 clocks never reaches the debounce threshold.
        start_seq();
        for (int i = 0; i < 5; i++) begin
            run(1, 0, 2);
            run(0, 0, 2);
        end
        run(0, 0, 15);
        check_pulses("bounce", none);
        check_int("bounce_level_hi", lvl_hi_cnt, 0);

        // Bouncy press: three 1-clock glitches, then a stable press.
        for (int i = 0; i < 3; i++) begin
            run(1, 0, 1);
            run(0, 0, 1);
        end
        start_seq();
        run(1, 0, 40);
        run(0, 0, 12);
        exp1 = '{6};
        check_pulses("bouncy", exp1);

        // Auto-repeat; final expiry coincides with release acceptance and must not pulse.
        start_seq();
        run(1, 1, 60);
        run(0, 1, 20);
        exp4 = '{6, 26, 34, 42, 50, 58};
        check_pulses("repeat", exp4);
        check("repeat_released", btn_level, 1'b0);

        // repeat_en drops in REPEAT; re-raising it while held does not re-arm.
        start_seq();
        run(1, 1, 28);
        run(1, 0, 3);
        run(1, 1, 40);
        run(0, 0, 15);
        exp5 = '{6, 26};
        check_pulses("repeat_drop", exp5);

        // Reset mid-hold clears outputs at once; the held press is re-debounced.
        start_seq();
        run(1, 0, 15);
        check("pre_reset_level", btn_level, 1'b1);
        reset = 1'b0;
        model_reset();
        #1;
        check("midrst_level", btn_level, 1'b0);
        check("midrst_pulse", btn_pulse, 1'b0);
        for (int i = 0; i < 3; i++) step();
        reset = 1'b1;
        start_seq();
        run(1, 0, 30);
        run(0, 0, 12);
        check_pulses("after_reset", exp1);

        // DEBOUNCE_CYCLES=16: 640 ns presses every 6400 ns.
        p2cnt = 0;
        consec2 = 0;
        button_in = 1'b0;
        for (int p = 0; p < 16; p++) begin
            btn2 = 1'b1;
            for (int i = 0; i < 32; i++) step();
            btn2 = 1'b0;
            for (int i = 0; i < 288; i++) step();
        end
        check_int("d16_pulses", p2cnt, 16);
        check_int("d16_consecutive", consec2, 0);
        check("d16_level_end", btn2_level, 1'b0);

        // Randomized runs, repeat_en changes and occasional async resets vs the model.
        for (int r = 0; r < 400; r++) begin
            logic b;
            logic ren;
            int   len;
            b   = 1'($urandom_range(0, 1));
            ren = 1'($urandom_range(0, 3) != 0);
            len = ($urandom_range(0, 4) == 0) ? $urandom_range(20, 60) : $urandom_range(1, 8);
            if ($urandom_range(0, 60) == 0) begin
                reset = 1'b0;
                model_reset();
                #1;
                check("rand_rst_level", btn_level, 1'b0);
                check("rand_rst_pulse", btn_pulse, 1'b0);
                run(0, ren, $urandom_range(1, 3));
                reset = 1'b1;
            end
            run(b, ren, len);
        end
        run(0, 0, 20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
